imem_boot_loader: RTL and testbench

- Upstream stage of the single-cycle core. Receives a byte stream from a serial receiver and writes a program into instruction memory.
- Holds the core in reset until the whole program has loaded and its checksum matches.
- Replaces backdoor writes into inst_mem with a real load path.
- Frame format, all fields little-endian 32-bit: word count N, then N instruction words, then the XOR checksum of the N words.

---
 rtl/imem_boot_loader_pkg.sv | 14 +
 rtl/imem_boot_loader_word_assembler.sv | 46 ++++
 rtl/imem_boot_loader.sv | 117 +++++++++++
 tb/tb_imem_boot_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        CHK,
        DONE,
        ERR
    } boot_state_e;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; pulses word_valid_o on the 4th byte.
module word_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] word_q, word_d;

    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        if (byte_valid_i) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
                2'd0:    word_d[7:0]   = byte_data_i;
                2'd1:    word_d[15:8]  = byte_data_i;
                2'd2:    word_d[23:16] = byte_data_i;
                default: word_d        = word_q;
            endcase
        end
    end

    // The top byte is never stored: the word is presented while it is on the bus.
    assign word_valid_o = byte_valid_i && (byte_idx_q == LAST_IDX);
    assign word_o       = {byte_data_i, word_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_idx_q <= 2'd0;
            word_q     <= 24'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program byte stream, writes instruction memory,
// and releases the core only once the XOR checksum has matched.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    boot_state_e       state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [31:0]       acc_q, acc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              word_valid;
    logic [31:0]       word;

    assign rx_ready = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (rx_valid && rx_ready),
        .byte_data_i  (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            HDR: begin
                if (word_valid) begin
                    if (word == 32'd0) begin
                        count_d = '0;
                        state_d = CHK;
                    end else if ({1'b0, word} > CAPACITY) begin
                        state_d = ERR;
                    end else begin
                        count_d = word[ADDR_W:0];
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_valid) begin
                    we_d    = 1'b1;
                    addr_d  = words_q[ADDR_W-1:0];
                    wdata_d = word;
                    words_d = words_q + 1'b1;
                    acc_d   = acc_q ^ word;
                    if (words_d == count_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (word_valid) begin
                    state_d = (word == acc_q) ? DONE : ERR;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= HDR;
            count_q <= '0;
            words_q <= '0;
            acc_q   <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            words_q <= words_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign core_run     = (state_q == DONE);
    assign load_done    = (state_q == DONE);
    assign load_err     = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed scenario bench for imem_boot_loader with hand-computed expectations.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    int                wc[$];

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_run     (core_run),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_log();
    endtask

    // last_c is the cycle stamp of the edge that accepted the word's 4th byte
    task automatic send_word(input logic [31:0] w, input bit gap, output int last_c);
        last_c = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = w[8*k +: 8];
            @(posedge clk);
            #1;
            last_c   = cyc;
            rx_valid = 1'b0;
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({imem_we, imem_addr, imem_wdata, core_run, load_done, load_err, words_loaded} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h run=%b done=%b err=%b wl=%0d, want all 0",
                     imem_we, imem_addr, imem_wdata, core_run, load_done, load_err, words_loaded);
        end
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_rx_ready: got %b want 1", rx_ready);
        end
        reset = 1'b1;
        clear_log();
    endtask

    task automatic run_frame1(input bit gap, input logic [31:0] chk, input string tag);
        int c, c0, c1;
        do_reset();
        send_word(32'h0000_0002, gap, c);
        send_word(32'hfe01_0113, gap, c0);
        send_word(32'h0281_2623, gap, c1);
        send_word(chk, gap, c);
        n_cmp++;
        if (wa.size() !== 2) begin
            n_mis++;
            $display("FAIL %s write_count: got %0d want 2", tag, wa.size());
        end
        if (wa.size() == 2) begin
            n_cmp++;
            if (wa[0] !== 8'd0 || wd[0] !== 32'hfe01_0113 || wc[0] !== c0) begin
                n_mis++;
                $display("FAIL %s write0: got addr=%h data=%h cyc=%0d want addr=00 data=fe010113 cyc=%0d",
                         tag, wa[0], wd[0], wc[0], c0);
            end
            n_cmp++;
            if (wa[1] !== 8'd1 || wd[1] !== 32'h0281_2623 || wc[1] !== c1) begin
                n_mis++;
                $display("FAIL %s write1: got addr=%h data=%h cyc=%0d want addr=01 data=02812623 cyc=%0d",
                         tag, wa[1], wd[1], wc[1], c1);
            end
        end
        n_cmp++;
        if (words_loaded !== 9'd2) begin
            n_mis++;
            $display("FAIL %s words_loaded: got %0d want 2", tag, words_loaded);
        end
    endtask

    task automatic test_load_ok(input bit gap, input string tag);
        int c;
        run_frame1(gap, 32'hfc80_2730, tag);
        n_cmp++;
        if ({load_done, core_run, load_err, rx_ready} !== 4'b1100) begin
            n_mis++;
            $display("FAIL %s final_flags: got done=%b run=%b err=%b ready=%b want 1 1 0 0",
                     tag, load_done, core_run, load_err, rx_ready);
        end
        // bytes offered in DONE must be ignored
        send_word(32'hdead_beef, 1'b0, c);
        n_cmp++;
        if (wa.size() !== 2 || words_loaded !== 9'd2 || load_done !== 1'b1) begin
            n_mis++;
            $display("FAIL %s done_ignores: got writes=%0d wl=%0d done=%b want 2 2 1",
                     tag, wa.size(), words_loaded, load_done);
        end
    endtask

    task automatic test_bad_checksum();
        run_frame1(1'b0, 32'h0000_0000, "badchk");
        n_cmp++;
        if ({load_err, core_run, load_done, rx_ready} !== 4'b1000) begin
            n_mis++;
            $display("FAIL badchk_flags: got err=%b run=%b done=%b ready=%b want 1 0 0 0",
                     load_err, core_run, load_done, rx_ready);
        end
    endtask

    task automatic test_zero_count();
        int c;
        do_reset();
        send_word(32'h0000_0000, 1'b0, c);
        n_cmp++;
        if (load_done !== 1'b0 || rx_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL zero_hdr_state: got done=%b ready=%b want 0 1", load_done, rx_ready);
        end
        send_word(32'h0000_0000, 1'b0, c);
        n_cmp++;
        if (wa.size() !== 0 || load_done !== 1'b1 || core_run !== 1'b1 || words_loaded !== 9'd0) begin
            n_mis++;
            $display("FAIL zero_count: got writes=%0d done=%b run=%b wl=%0d want 0 1 1 0",
                     wa.size(), load_done, core_run, words_loaded);
        end
    endtask

    task automatic test_overflow();
        int c;
        do_reset();
        send_word(32'h0000_0101, 1'b0, c);
        n_cmp++;
        if (load_err !== 1'b1 || rx_ready !== 1'b0 || core_run !== 1'b0) begin
            n_mis++;
            $display("FAIL overflow_err: got err=%b ready=%b run=%b want 1 0 0", load_err, rx_ready, core_run);
        end
        send_word(32'h1122_3344, 1'b0, c);
        send_word(32'h5566_7788, 1'b0, c);
        n_cmp++;
        if (wa.size() !== 0 || words_loaded !== 9'd0 || load_err !== 1'b1) begin
            n_mis++;
            $display("FAIL overflow_nowrite: got writes=%0d wl=%0d err=%b want 0 0 1",
                     wa.size(), words_loaded, load_err);
        end
    endtask

    task automatic test_full_capacity();
        int c;
        logic [31:0] x;
        logic [31:0] w;
        do_reset();
        x = 32'd0;
        send_word(32'h0000_0100, 1'b0, c);
        for (int i = 0; i < 256; i++) begin
            w = 32'hA500_0000 + (i * 32'h0001_0003);
            x = x ^ w;
            send_word(w, 1'b0, c);
        end
        send_word(x, 1'b0, c);
        n_cmp++;
        if (wa.size() !== 256 || words_loaded !== 9'd256) begin
            n_mis++;
            $display("FAIL full_count: got writes=%0d wl=%0d want 256 256", wa.size(), words_loaded);
        end
        if (wa.size() == 256) begin
            n_cmp++;
            if (wa[255] !== 8'hff || wd[255] !== (32'hA500_0000 + 32'd255 * 32'h0001_0003) || wa[128] !== 8'h80) begin
                n_mis++;
                $display("FAIL full_last_write: got addr=%h data=%h mid_addr=%h want ff %h 80",
                         wa[255], wd[255], wa[128], 32'hA500_0000 + 32'd255 * 32'h0001_0003);
            end
        end
        n_cmp++;
        if (load_done !== 1'b1 || load_err !== 1'b0) begin
            n_mis++;
            $display("FAIL full_flags: got done=%b err=%b want 1 0", load_done, load_err);
        end
    endtask

    task automatic test_mid_reset();
        int c, c0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = (k < 4) ? ((k == 0) ? 8'h02 : 8'h00) : ((k == 4) ? 8'h13 : 8'h01);
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({imem_we, imem_addr, imem_wdata, core_run, load_done, load_err, words_loaded} !== '0) begin
            n_mis++;
            $display("FAIL midreset_outputs: got we=%b addr=%h wdata=%h run=%b done=%b err=%b wl=%0d, want all 0",
                     imem_we, imem_addr, imem_wdata, core_run, load_done, load_err, words_loaded);
        end
        reset = 1'b1;
        clear_log();
        send_word(32'h0000_0001, 1'b0, c);
        send_word(32'h0050_0793, 1'b0, c0);
        send_word(32'h0050_0793, 1'b0, c);
        n_cmp++;
        if (wa.size() !== 1) begin
            n_mis++;
            $display("FAIL midreset_writes: got %0d want 1", wa.size());
        end
        if (wa.size() == 1) begin
            n_cmp++;
            if (wa[0] !== 8'd0 || wd[0] !== 32'h0050_0793 || wc[0] !== c0) begin
                n_mis++;
                $display("FAIL midreset_write0: got addr=%h data=%h cyc=%0d want 00 00500793 %0d",
                         wa[0], wd[0], wc[0], c0);
            end
        end
        n_cmp++;
        if (load_done !== 1'b1 || core_run !== 1'b1 || words_loaded !== 9'd1) begin
            n_mis++;
            $display("FAIL midreset_flags: got done=%b run=%b wl=%0d want 1 1 1", load_done, core_run, words_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_load_ok(1'b0, "load_ok");
        test_bad_checksum();
        test_zero_count();
        test_overflow();
        test_load_ok(1'b1, "gaps");
        test_mid_reset();
        test_full_capacity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
